// File: rtl/matmul_pkg.sv
// Shared MAC-array definitions: default sizes, lane width and the operand feeder state encoding.
package matmul_pkg;
  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int LANE_W = 2 * DW;
  localparam int IDX_W  = $clog2(N);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2
  } feeder_state_t;
endpackage

// File: rtl/operand_bank.sv
// N*N x DW register file with one write port and N combinational read lanes.
// COL_READ=0 reads row sel_i (lane k = M[sel][k]); COL_READ=1 reads column sel_i (lane k = M[k][sel]).
module operand_bank #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter bit COL_READ = 1'b0,
  localparam int IW      = $clog2(N),
  localparam int AW      = 2 * IW
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [IW-1:0]   sel_i,
  output logic [N*DW-1:0] rdata_o
);
  // Contents are don't-care after reset, so the array carries no reset.
  logic [DW-1:0] mem_q [N*N];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  for (genvar k = 0; k < N; k++) begin : g_rd
    localparam logic [IW-1:0] K = IW'(k);
    if (COL_READ) begin : g_col
      assign rdata_o[k*DW +: DW] = mem_q[{K, sel_i}];
    end else begin : g_row
      assign rdata_o[k*DW +: DW] = mem_q[{sel_i, K}];
    end
  end
endmodule

// File: rtl/matrix_operand_feeder.sv
// Buffers A then B (row-major) and issues the N*N row/column operand vectors with (i,j) tags.
// First vector 1 cycle after the last B accept; output register advances only when !out_valid | out_ready.
module matrix_operand_feeder #(
  parameter int N   = matmul_pkg::N,
  parameter int DW  = matmul_pkg::DW,
  localparam int IW = $clog2(N),
  localparam int OW = 2 * DW * N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [IW-1:0] out_row,
  output logic [IW-1:0] out_col,
  output logic          out_last,
  output logic          done
);
  import matmul_pkg::*;

  localparam int AW = 2 * IW;
  localparam int LW = 2 * DW;

  feeder_state_t state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] ld_idx_q;
  logic          all_ld_q;
  logic          out_valid_q;
  logic [OW-1:0] out_data_q;
  logic [IW-1:0] out_row_q;
  logic [IW-1:0] out_col_q;
  logic          out_last_q;
  logic          done_q;

  logic            ld_en;
  logic            last_hs;
  logic            ld_last;
  logic [N*DW-1:0] a_rd;
  logic [N*DW-1:0] b_rd;
  logic [OW-1:0]   issue_dat_d;

  assign in_ready  = (state_q != ISSUE);
  assign ld_en     = !out_valid_q || out_ready;
  assign last_hs   = out_valid_q && out_ready && out_last_q;
  assign ld_last   = &ld_idx_q;

  operand_bank #(.N(N), .DW(DW), .COL_READ(1'b0)) u_bank_a (
    .clk     (clk),
    .we_i    (in_valid && (state_q == LOAD_A)),
    .waddr_i (cnt_q),
    .wdata_i (in_data),
    .sel_i   (ld_idx_q[AW-1:IW]),
    .rdata_o (a_rd)
  );

  operand_bank #(.N(N), .DW(DW), .COL_READ(1'b1)) u_bank_b (
    .clk     (clk),
    .we_i    (in_valid && (state_q == LOAD_B)),
    .waddr_i (cnt_q),
    .wdata_i (in_data),
    .sel_i   (ld_idx_q[IW-1:0]),
    .rdata_o (b_rd)
  );

  // Lane k: A element in the low half, B element in the high half.
  always_comb begin
    issue_dat_d = '0;
    for (int k = 0; k < N; k++) begin
      issue_dat_d[k*LW +: DW]      = a_rd[k*DW +: DW];
      issue_dat_d[k*LW + DW +: DW] = b_rd[k*DW +: DW];
    end
  end

  // ld_idx_q is the (i,j) of the next vector to load into the output register,
  // so the register always holds the vector whose handshake is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      ld_idx_q    <= '0;
      all_ld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LOAD_A, LOAD_B: begin
          if (in_valid) begin
            cnt_q <= cnt_q + AW'(1);
            if (&cnt_q) state_q <= (state_q == LOAD_A) ? LOAD_B : ISSUE;
          end
        end
        ISSUE: begin
          if (ld_en) begin
            if (last_hs) begin
              state_q     <= LOAD_A;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              ld_idx_q    <= '0;
              all_ld_q    <= 1'b0;
              done_q      <= 1'b1;
            end else if (!all_ld_q) begin
              out_valid_q <= 1'b1;
              out_data_q  <= issue_dat_d;
              out_row_q   <= ld_idx_q[AW-1:IW];
              out_col_q   <= ld_idx_q[IW-1:0];
              out_last_q  <= ld_last;
              ld_idx_q    <= ld_idx_q + AW'(1);
              all_ld_q    <= ld_last;
            end
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
endmodule

// File: tb/tb_matrix_operand_feeder.sv
// Directed bench: matrix-level model of A/B plus a per-cycle compare process and a result collector.
module tb_matrix_operand_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_last;
  logic        done;

  matrix_operand_feeder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  am [NN];
  logic [7:0]  bm [NN];
  int          exp_idx  = 0;
  bit          armed    = 0;
  bit          done_exp = 0;
  int          done_cnt = 0;
  logic [63:0] first_vec;
  logic [63:0] last_vec;
  int          cres [N][N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The operand vector the spec demands for (i,j): lane k = {B[k][j], A[i][k]}.
  function automatic logic [63:0] model_vec(input int i, input int j);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      v[k*16 +: 8]     = am[i*N + k];
      v[k*16 + 8 +: 8] = bm[k*N + j];
    end
    return v;
  endfunction

  always @(negedge clk) begin : monitor
    int i, j, s;
    if (rst_n === 1'b1) begin
      check("done", done, done_exp);
      done_exp = 0;
      if (done) begin
        done_cnt++;
        check("in_ready_at_done", in_ready, 1);
        check("valid_at_done", out_valid, 0);
      end
      if (out_valid) begin
        if (!armed || exp_idx >= NN) begin
          total++;
          bad++;
          $display("FAIL unexpected_vector: got valid with idx %0d armed %0d expected none", exp_idx, armed);
        end else begin
          i = exp_idx / N;
          j = exp_idx % N;
          check("vec_data", out_data, model_vec(i, j));
          check("vec_row", out_row, i);
          check("vec_col", out_col, j);
          check("vec_last", out_last, exp_idx == NN - 1);
          check("in_ready_issue", in_ready, 0);
          if (exp_idx == 0) first_vec = out_data;
          if (exp_idx == NN - 1) last_vec = out_data;
          if (out_ready) begin
            s = 0;
            for (int k = 0; k < N; k++) s += int'(out_data[k*16 +: 8]) * int'(out_data[k*16 + 8 +: 8]);
            cres[out_row][out_col] = s;
            exp_idx++;
            if (exp_idx == NN) done_exp = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit gaps);
    bit acc;
    if (gaps) begin
      for (int g = 0; g < 8 && $urandom_range(1) == 0; g++) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    acc = 0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready low for 50 cycles expected accept");
    end
  endtask

  task automatic load(input bit gaps, input int nb);
    for (int x = 0; x < NN; x++) send(am[x], gaps);
    for (int x = 0; x < nb; x++) send(bm[x], gaps);
    if (nb == NN) armed = 1;
  endtask

  // mode 0: out_ready=1; mode 1: out_ready toggles; mode 2: out_ready=1 plus junk writes.
  task automatic run_issue(input int mode, input int stop_after);
    bit fin;
    fin = 0;
    out_ready = 1'b1;
    if (mode == 2) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
    end
    @(negedge clk);
    check("first_latency_lo", out_valid, 0);
    check("in_ready_enter_issue", in_ready, 0);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      tick();
      if (mode == 1) out_ready = ~out_ready;
      if (exp_idx >= NN) in_valid = 1'b0;
      if (cyc == 0) begin
        @(negedge clk);
        check("first_latency_hi", out_valid, 1);
      end
      if (stop_after < NN && exp_idx >= stop_after) fin = 1;
      if (done_cnt > 0) fin = 1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got %0d handshakes expected %0d", exp_idx, NN);
    end
    if (stop_after >= NN) begin
      check("handshakes", exp_idx, NN);
      check("done_count", done_cnt, 1);
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          int r;
          r = 0;
          for (int k = 0; k < N; k++) r += int'(am[i*N + k]) * int'(bm[k*N + j]);
          check("c_result", cres[i][j], r);
        end
      armed    = 0;
      exp_idx  = 0;
      done_cnt = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_last", out_last, 0);
    armed     = 0;
    exp_idx   = 0;
    done_exp  = 0;
    done_cnt  = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic rand_mats();
    for (int x = 0; x < NN; x++) begin
      am[x] = 8'($urandom_range(126));
      bm[x] = 8'($urandom_range(126));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #3;
    do_reset();

    // Identity x ramp with literal pins on the first/last vector and one product.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        am[r*N + c] = (r == c) ? 8'd1 : 8'd0;
        bm[r*N + c] = 8'(4*r + c + 1);
      end
    load(0, NN);
    run_issue(0, NN);
    check("lit_first_vec", first_vec, 64'h0D00_0900_0500_0101);
    check("lit_last_vec", last_vec, 64'h1001_0C00_0800_0400);
    check("lit_c12", cres[1][2], 7);

    // Backpressure on alternate cycles.
    rand_mats();
    load(0, NN);
    run_issue(1, NN);

    // Bubbly load.
    rand_mats();
    load(1, NN);
    run_issue(0, NN);

    // Junk writes during ISSUE, then a fresh reload.
    rand_mats();
    load(0, NN);
    run_issue(2, NN);
    rand_mats();
    load(0, NN);
    run_issue(0, NN);

    // Reset after 5 B elements, then full reload.
    rand_mats();
    load(0, 5);
    do_reset();
    rand_mats();
    load(0, NN);
    run_issue(0, NN);

    // Reset after 7 issued vectors; no done may follow.
    rand_mats();
    load(0, NN);
    run_issue(0, 7);
    do_reset();
    for (int c = 0; c < 5; c++) tick();
    check("no_done_after_reset", done_cnt, 0);
    rand_mats();
    load(1, NN);
    run_issue(1, NN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected summary");
    $fatal(1, "timeout");
  end
endmodule
